imm_hazard_ctrl: RTL and testbench

ID-stage controller for the pipelined MIPS datapath.
- Decodes the IF/ID instruction opcode.
- Drives the sign extender's zero-extend control and the immediate-select code.
- Detects load-use hazards and stalls IF/ID and the PC for a parameterised number of cycles, inserting bubbles into ID/EX.
- Registers the ID/EX immediate controls and honours branch flushes.

---
 rtl/imm_hazard_ctrl.sv | 142 ++++++++++++++
 tb/tb_imm_hazard_ctrl.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/imm_hazard_ctrl.sv
// rtl/imm_hazard_ctrl.sv - ID-stage immediate decode, load-use stall control and ID/EX immediate register
module imm_hazard_ctrl #(
    parameter int STALL_CYCLES = 1,
    parameter int CNT_W        = 3
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic [31:0] Instr,
    input  logic        Instr_Valid,
    input  logic        IdEx_MemRead,
    input  logic [4:0]  IdEx_Rt,
    input  logic        Flush,
    output logic        Ext_Zero,
    output logic        Pc_Write,
    output logic        IfId_Write,
    output logic        Stall,
    output logic        Ex_Valid,
    output logic [1:0]  Ex_ImmSel,
    output logic        Ex_Ext_Zero,
    output logic        Ex_Illegal
);

    typedef enum logic {RUN, STALL} state_t;

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(STALL_CYCLES > 1 ? STALL_CYCLES - 2 : 0);

    state_t           state;
    logic [CNT_W-1:0] cnt;

    logic [5:0] opcode;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [1:0] imm_sel;
    logic       ext_zero;
    logic       reads_rs;
    logic       reads_rt;
    logic       illegal;
    logic       hazard;
    logic       stall_now;
    logic       unused_imm_bits;

    assign opcode          = Instr[31:26];
    assign rs              = Instr[25:21];
    assign rt              = Instr[20:16];
    assign unused_imm_bits = ^Instr[15:0];

    always_comb begin
        imm_sel  = 2'd0;
        ext_zero = 1'b0;
        reads_rs = 1'b0;
        reads_rt = 1'b0;
        illegal  = 1'b0;
        case (opcode)
            6'h00: begin
                reads_rs = 1'b1;
                reads_rt = 1'b1;
            end
            6'h08, 6'h09, 6'h0A, 6'h0B: begin
                imm_sel  = 2'd1;
                reads_rs = 1'b1;
            end
            6'h0C, 6'h0D, 6'h0E: begin
                imm_sel  = 2'd2;
                ext_zero = 1'b1;
                reads_rs = 1'b1;
            end
            6'h0F: begin
                imm_sel  = 2'd3;
                ext_zero = 1'b1;
            end
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
                imm_sel  = 2'd1;
                reads_rs = 1'b1;
            end
            6'h28, 6'h29, 6'h2B, 6'h04, 6'h05: begin
                imm_sel  = 2'd1;
                reads_rs = 1'b1;
                reads_rt = 1'b1;
            end
            6'h02, 6'h03: begin
                imm_sel = 2'd0;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

    // $zero is never a real load destination, so it cannot create a dependency
    assign hazard = Instr_Valid & IdEx_MemRead & (IdEx_Rt != 5'd0) &
                    ((reads_rs & (rs == IdEx_Rt)) | (reads_rt & (rt == IdEx_Rt)));

    assign stall_now  = !Flush && ((state == STALL) || hazard);
    assign Stall      = stall_now;
    assign Pc_Write   = !stall_now;
    assign IfId_Write = !stall_now;
    assign Ext_Zero   = ext_zero;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state       <= RUN;
            cnt         <= '0;
            Ex_Valid    <= 1'b0;
            Ex_ImmSel   <= 2'd0;
            Ex_Ext_Zero <= 1'b0;
            Ex_Illegal  <= 1'b0;
        end else if (Flush) begin
            state       <= RUN;
            cnt         <= '0;
            Ex_Valid    <= 1'b0;
            Ex_ImmSel   <= 2'd0;
            Ex_Ext_Zero <= 1'b0;
            Ex_Illegal  <= 1'b0;
        end else if (state == STALL) begin
            Ex_Valid    <= 1'b0;
            Ex_ImmSel   <= 2'd0;
            Ex_Ext_Zero <= 1'b0;
            Ex_Illegal  <= 1'b0;
            if (cnt == '0) begin
                state <= RUN;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end else if (hazard) begin
            Ex_Valid    <= 1'b0;
            Ex_ImmSel   <= 2'd0;
            Ex_Ext_Zero <= 1'b0;
            Ex_Illegal  <= 1'b0;
            // the hazard cycle itself is the first stall cycle
            if (STALL_CYCLES > 1) begin
                state <= STALL;
                cnt   <= CNT_INIT;
            end
        end else begin
            Ex_Valid    <= Instr_Valid;
            Ex_ImmSel   <= Instr_Valid ? imm_sel : 2'd0;
            Ex_Ext_Zero <= Instr_Valid & ext_zero;
            Ex_Illegal  <= Instr_Valid & illegal;
        end
    end

endmodule

// File: tb/tb_imm_hazard_ctrl.sv
// tb/tb_imm_hazard_ctrl.sv - scoreboard bench running 1-cycle and 3-cycle stall variants side by side
module tb_imm_hazard_ctrl;

    logic        Clk;
    logic        Rst_n;
    logic [31:0] Instr;
    logic        Instr_Valid;
    logic        IdEx_MemRead;
    logic [4:0]  IdEx_Rt;
    logic        Flush;

    logic       ez1, pw1, iw1, st1, v1, ezx1, ill1;
    logic [1:0] sel1;
    logic       ez3, pw3, iw3, st3, v3, ezx3, ill3;
    logic [1:0] sel3;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string      name;
        logic [3:0] c1;
        logic [3:0] c3;
        logic [4:0] r1;
        logic [4:0] r3;
    } rec_t;

    rec_t sbq[$];

    imm_hazard_ctrl #(.STALL_CYCLES(1), .CNT_W(3)) u1 (
        .Clk(Clk), .Rst_n(Rst_n), .Instr(Instr), .Instr_Valid(Instr_Valid),
        .IdEx_MemRead(IdEx_MemRead), .IdEx_Rt(IdEx_Rt), .Flush(Flush),
        .Ext_Zero(ez1), .Pc_Write(pw1), .IfId_Write(iw1), .Stall(st1),
        .Ex_Valid(v1), .Ex_ImmSel(sel1), .Ex_Ext_Zero(ezx1), .Ex_Illegal(ill1)
    );

    imm_hazard_ctrl #(.STALL_CYCLES(3), .CNT_W(3)) u3 (
        .Clk(Clk), .Rst_n(Rst_n), .Instr(Instr), .Instr_Valid(Instr_Valid),
        .IdEx_MemRead(IdEx_MemRead), .IdEx_Rt(IdEx_Rt), .Flush(Flush),
        .Ext_Zero(ez3), .Pc_Write(pw3), .IfId_Write(iw3), .Stall(st3),
        .Ex_Valid(v3), .Ex_ImmSel(sel3), .Ex_Ext_Zero(ezx3), .Ex_Illegal(ill3)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    // comb tuple {Ext_Zero,Pc_Write,IfId_Write,Stall}; reg tuple {Ex_Valid,Ex_ImmSel,Ex_Ext_Zero,Ex_Illegal}
    task automatic step(input string nm, input logic [31:0] ins, input logic vld,
                        input logic mr, input logic [4:0] rt, input logic fl,
                        input logic [3:0] c1, input logic [3:0] c3,
                        input logic [4:0] r1, input logic [4:0] r3);
        rec_t r;
        @(negedge Clk);
        #1;
        Instr        = ins;
        Instr_Valid  = vld;
        IdEx_MemRead = mr;
        IdEx_Rt      = rt;
        Flush        = fl;
        r.name = nm;
        r.c1 = c1;
        r.c3 = c3;
        r.r1 = r1;
        r.r3 = r3;
        sbq.push_back(r);
    endtask

    initial begin : monitor
        rec_t r;
        forever begin
            @(negedge Clk);
            #3;
            if (sbq.size() > 0) begin
                r = sbq.pop_front();
                chk({r.name, " comb S1"}, {4'b0, ez1, pw1, iw1, st1}, {4'b0, r.c1});
                chk({r.name, " comb S3"}, {4'b0, ez3, pw3, iw3, st3}, {4'b0, r.c3});
                @(posedge Clk);
                #1;
                chk({r.name, " idex S1"}, {3'b0, v1, sel1, ezx1, ill1}, {3'b0, r.r1});
                chk({r.name, " idex S3"}, {3'b0, v3, sel3, ezx3, ill3}, {3'b0, r.r3});
            end
        end
    end

    initial begin : watchdog
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    localparam logic [31:0] ORI  = 32'h34058000;
    localparam logic [31:0] ADDI = 32'h20058000;
    localparam logic [31:0] LUI3 = 32'h3C031234;
    localparam logic [31:0] ADD  = 32'h010A4820;
    localparam logic [31:0] LUI8 = 32'h3C081234;
    localparam logic [31:0] ILL  = 32'hFC000000;

    initial begin : stimulus
        Rst_n        = 1'b0;
        Instr        = 32'h0;
        Instr_Valid  = 1'b0;
        IdEx_MemRead = 1'b0;
        IdEx_Rt      = 5'd0;
        Flush        = 1'b0;
        repeat (2) @(posedge Clk);
        #2;
        Rst_n = 1'b1;
        #1;
        chk("reset S1", {1'b0, v1, sel1, ezx1, ill1, pw1, iw1, st1}, 8'b0_00000_1_1_0 >> 0);
        chk("reset S3", {1'b0, v3, sel3, ezx3, ill3, pw3, iw3, st3}, 8'b0000_0110);

        step("idle",      32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 4'b0110, 4'b0110, 5'b00000, 5'b00000);
        step("ori",       ORI,   1'b1, 1'b0, 5'd0, 1'b0, 4'b1110, 4'b1110, 5'b11010, 5'b11010);
        step("addi",      ADDI,  1'b1, 1'b0, 5'd0, 1'b0, 4'b0110, 4'b0110, 5'b10100, 5'b10100);
        step("lui",       LUI3,  1'b1, 1'b0, 5'd0, 1'b0, 4'b1110, 4'b1110, 5'b11110, 5'b11110);
        step("hazard c1", ADD,   1'b1, 1'b1, 5'd8, 1'b0, 4'b0001, 4'b0001, 5'b00000, 5'b00000);
        step("hazard c2", ADD,   1'b1, 1'b0, 5'd8, 1'b0, 4'b0110, 4'b0001, 5'b10000, 5'b00000);
        step("hazard c3", ADD,   1'b1, 1'b0, 5'd8, 1'b0, 4'b0110, 4'b0001, 5'b10000, 5'b00000);
        step("issue add", ADD,   1'b1, 1'b0, 5'd8, 1'b0, 4'b0110, 4'b0110, 5'b10000, 5'b10000);
        step("rt zero",   ADD,   1'b1, 1'b1, 5'd0, 1'b0, 4'b0110, 4'b0110, 5'b10000, 5'b10000);
        step("lui noread",LUI8,  1'b1, 1'b1, 5'd8, 1'b0, 4'b1110, 4'b1110, 5'b11110, 5'b11110);
        step("fl hazard", ADD,   1'b1, 1'b1, 5'd8, 1'b0, 4'b0001, 4'b0001, 5'b00000, 5'b00000);
        step("fl abort",  ADD,   1'b1, 1'b0, 5'd8, 1'b1, 4'b0110, 4'b0110, 5'b00000, 5'b00000);
        step("post flush",ADD,   1'b1, 1'b0, 5'd8, 1'b0, 4'b0110, 4'b0110, 5'b10000, 5'b10000);
        step("fl ori",    ORI,   1'b1, 1'b0, 5'd0, 1'b1, 4'b1110, 4'b1110, 5'b00000, 5'b00000);
        step("illegal",   ILL,   1'b1, 1'b0, 5'd0, 1'b0, 4'b0110, 4'b0110, 5'b10001, 5'b10001);
        step("rst hazard",ADD,   1'b1, 1'b1, 5'd8, 1'b0, 4'b0001, 4'b0001, 5'b00000, 5'b00000);

        @(posedge Clk);
        #2;
        IdEx_MemRead = 1'b0;
        #1;
        chk("mid stall S3", {6'b0, pw3, st3}, 8'b0000_0001);
        Rst_n = 1'b0;
        #1;
        chk("async rst S3", {3'b0, v3, sel3, ezx3, ill3, pw3, iw3, st3} & 8'h1F, 8'b0000_0110);
        @(negedge Clk);
        #2;
        Rst_n = 1'b1;

        step("after rst", ADD,   1'b1, 1'b0, 5'd8, 1'b0, 4'b0110, 4'b0110, 5'b10000, 5'b10000);
        @(posedge Clk);
        #2;
        chk("queue drained", 8'(sbq.size()), 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
